// File: rtl/fft_output_serializer.sv
// fft_output_serializer
// Takes result pairs (top = even-index sample, bot = odd-index sample, plus the
// block exponent) from the dual-lane FFT core. It buffers them in a small pair
// FIFO and re-serializes them into one complex sample per clock for the
// capture/DMA path. It regenerates sop/eop and checks frame length on the
// input side, holding a sticky error flag.
//
// Ports
//   clk_fft, reset_n         single clock, asynchronous active-low reset
//   in_valid / in_ready      pair handshake
//   in_sop, in_eop, in_exp   pair framing and block exponent
//   in_{real,imag}_{top,bot} the two samples of the pair
//   out_valid / out_ready    sample handshake
//   out_sop, out_eop         first / last sample of frame
//   out_real, out_imag       sample
//   out_exp                  exponent travelling with the sample
//   frame_err / clear_err    sticky framing error and its synchronous clear
module fft_output_serializer #(
  parameter int data_width = 16,
  parameter int exp_width  = 6,
  parameter int fft_points = 32768,
  parameter int fifo_depth = 4
) (
  input  logic                  clk_fft,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic [exp_width-1:0]  in_exp,
  input  logic [data_width-1:0] in_real_top,
  input  logic [data_width-1:0] in_imag_top,
  input  logic [data_width-1:0] in_real_bot,
  input  logic [data_width-1:0] in_imag_bot,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [data_width-1:0] out_real,
  output logic [data_width-1:0] out_imag,
  output logic [exp_width-1:0]  out_exp,
  output logic                  frame_err,
  input  logic                  clear_err
);

  localparam int AW     = $clog2(fifo_depth);
  localparam int PAIRS  = fft_points / 2;
  localparam int PCW    = $clog2(PAIRS);
  localparam int LAST_I = PAIRS - 1;
  localparam int ONE_I  = 1;
  localparam logic [AW:0]    DEPTH_C = fifo_depth[AW:0];
  localparam logic [PCW-1:0] LAST    = LAST_I[PCW-1:0];
  localparam logic [PCW-1:0] ONE     = ONE_I[PCW-1:0];

  typedef struct packed {
    logic                  sop;
    logic                  eop;
    logic [exp_width-1:0]  exp;
    logic [data_width-1:0] rt;
    logic [data_width-1:0] it;
    logic [data_width-1:0] rb;
    logic [data_width-1:0] ib;
  } pair_t;

  typedef enum logic {LANE_TOP, LANE_BOT} lane_t;

  pair_t           mem [fifo_depth];
  pair_t           in_pair;
  pair_t           src;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count, count_nx;
  lane_t           lane, lane_nx;
  logic            push, pop, load, fifo_empty;

  logic                  out_valid_nx, out_sop_nx, out_eop_nx;
  logic [data_width-1:0] out_real_nx, out_imag_nx;
  logic [exp_width-1:0]  out_exp_nx;

  logic [PCW-1:0]  pc, pc_nx;
  logic            frame_viol, frame_err_nx;

  assign in_pair = '{sop: in_sop, eop: in_eop, exp: in_exp,
                     rt: in_real_top, it: in_imag_top,
                     rb: in_real_bot, ib: in_imag_bot};

  assign in_ready   = reset_n && (count < DEPTH_C);
  assign push       = in_valid && in_ready;
  assign fifo_empty = (count == '0);

  // With an empty FIFO the incoming pair feeds the output register directly,
  // so its top sample appears the cycle after acceptance. The pair is still
  // written to the FIFO, where it waits as head until its bot sample goes out.
  // lane is always LANE_TOP while the FIFO is empty.
  assign src  = fifo_empty ? in_pair : mem[rd_ptr];
  assign load = (!out_valid || out_ready) && (!fifo_empty || push);
  assign pop  = load && (lane == LANE_BOT);

  always_comb begin
    count_nx = count;
    case ({push, pop})
      2'b10:   count_nx = count + 1'b1;
      2'b01:   count_nx = count - 1'b1;
      default: count_nx = count;
    endcase
  end

  always_ff @(posedge clk_fft) begin
    if (push) mem[wr_ptr] <= in_pair;
  end

  always_ff @(posedge clk_fft or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nx;
    end
  end

  // Output register and lane selection
  always_comb begin
    out_valid_nx = out_valid;
    out_sop_nx   = out_sop;
    out_eop_nx   = out_eop;
    out_real_nx  = out_real;
    out_imag_nx  = out_imag;
    out_exp_nx   = out_exp;
    lane_nx      = lane;
    if (load) begin
      out_valid_nx = 1'b1;
      out_exp_nx   = src.exp;
      if (lane == LANE_TOP) begin
        out_real_nx = src.rt;
        out_imag_nx = src.it;
        out_sop_nx  = src.sop;
        out_eop_nx  = 1'b0;
        lane_nx     = LANE_BOT;
      end else begin
        out_real_nx = src.rb;
        out_imag_nx = src.ib;
        out_sop_nx  = 1'b0;
        out_eop_nx  = src.eop;
        lane_nx     = LANE_TOP;
      end
    end else if (out_ready) begin
      out_valid_nx = 1'b0;
    end
  end

  always_ff @(posedge clk_fft or negedge reset_n) begin
    if (!reset_n) begin
      lane      <= LANE_TOP;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
      out_exp   <= '0;
    end else begin
      lane      <= lane_nx;
      out_valid <= out_valid_nx;
      out_sop   <= out_sop_nx;
      out_eop   <= out_eop_nx;
      out_real  <= out_real_nx;
      out_imag  <= out_imag_nx;
      out_exp   <= out_exp_nx;
    end
  end

  // Frame check: sop must coincide with pair 0 and eop with the last pair.
  // Counter priority on a violation: eop ends the frame, else sop resyncs to 1,
  // else the counter wraps at the last pair.
  always_comb begin
    frame_viol = 1'b0;
    pc_nx      = pc;
    if (push) begin
      frame_viol = (in_sop != (pc == '0)) || (in_eop != (pc == LAST));
      if (in_eop)          pc_nx = '0;
      else if (in_sop)     pc_nx = ONE;
      else if (pc == LAST) pc_nx = '0;
      else                 pc_nx = pc + ONE;
    end
    frame_err_nx = (clear_err ? 1'b0 : frame_err) || frame_viol;
  end

  always_ff @(posedge clk_fft or negedge reset_n) begin
    if (!reset_n) begin
      pc        <= '0;
      frame_err <= 1'b0;
    end else begin
      pc        <= pc_nx;
      frame_err <= frame_err_nx;
    end
  end

endmodule
